// File: rtl/cmp_pkg.sv
// cmp_pkg: relation encodings and helpers shared by the comparator pipeline.
// Stage-1 flag bundle and result select live here so every stage agrees.
package cmp_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t CMP_EQ = 3'd0;
    localparam mode_t CMP_NE = 3'd1;
    localparam mode_t CMP_LT = 3'd2;
    localparam mode_t CMP_GE = 3'd3;
    localparam mode_t CMP_LE = 3'd4;
    localparam mode_t CMP_GT = 3'd5;

    typedef struct packed {
        logic  lt;
        logic  eq;
        mode_t mode;
    } s1_t;

    function automatic logic mode_reserved(input mode_t m);
        return m > CMP_GT;
    endfunction

    // Reserved encodings fall through to 0.
    function automatic logic mode_select(
        input mode_t m,
        input logic  lt,
        input logic  eq
    );
        logic r;
        r = 1'b0;
        case (m)
            CMP_EQ:  r = eq;
            CMP_NE:  r = !eq;
            CMP_LT:  r = lt;
            CMP_GE:  r = !lt;
            CMP_LE:  r = lt | eq;
            CMP_GT:  r = !(lt | eq);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_flags.sv
// cmp_flags: extend-and-subtract on a WIDTH+1 carry chain giving LT/EQ.
// The extra bit keeps LT exact for every signed or unsigned operand pair.
module cmp_flags #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             lt_o,
    output logic             eq_o
);

    logic [WIDTH:0] x0;
    logic [WIDTH:0] x1;
    logic [WIDTH:0] d;

    assign x0 = {signed_i & a_i[WIDTH-1], a_i};
    assign x1 = {signed_i & b_i[WIDTH-1], b_i};
    assign d  = x0 + ~x1 + {{WIDTH{1'b0}}, 1'b1};

    assign lt_o = d[WIDTH];
    // Zero difference on the extended chain is exactly I0 == I1.
    assign eq_o = (d == '0);

endmodule

// File: rtl/cmp_pipe.sv
// cmp_pipe: two-stage valid/ready comparator, six relations, signed/unsigned.
// Stage 1 holds LT/EQ/MODE; stage 2 holds the selected result O.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SIGNED,
    input  logic [2:0]       MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             O,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             ERR
);

    logic lt;
    logic eq;
    logic adv2;
    logic in_fire;
    logic s2_load;

    s1_t  s1_q, s1_d;
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic o_q, o_d;
    logic err_q, err_d;

    cmp_flags #(
        .WIDTH(WIDTH)
    ) u_flags (
        .a_i      (I0),
        .b_i      (I1),
        .signed_i (SIGNED),
        .lt_o     (lt),
        .eq_o     (eq)
    );

    assign adv2     = !out_valid_q || OUT_READY;
    assign IN_READY = !s1_valid_q || adv2;
    assign in_fire  = IN_VALID && IN_READY;
    assign s2_load  = s1_valid_q && adv2;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d       = '{lt: lt, eq: eq, mode: MODE};
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        o_d         = o_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            o_d         = mode_select(s1_q.mode, s1_q.lt, s1_q.eq);
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    assign err_d = err_q | (in_fire & mode_reserved(MODE));

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            o_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            err_q       <= err_d;
        end
    end

    assign O         = o_q;
    assign OUT_VALID = out_valid_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: WIDTH=8 and WIDTH=2 comparators against an integer model.
// Directed literals pin the model; random traffic exercises the handshake.
module tb_cmp_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    logic [7:0] I0, I1;
    logic       SIGNED, IN_VALID, OUT_READY;
    logic [2:0] MODE;
    logic       IN_READY, O, OUT_VALID, ERR;

    logic [1:0] b_i0, b_i1;
    logic       b_sgn, b_iv, b_or;
    logic [2:0] b_mode;
    logic       b_ir, b_o, b_ov, b_err;

    cmp_pipe #(.WIDTH(8)) dut8 (
        .CLK(clk), .ASYNCRESETN(rst_n),
        .I0(I0), .I1(I1), .SIGNED(SIGNED), .MODE(MODE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .O(O), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ERR(ERR)
    );

    cmp_pipe #(.WIDTH(2)) dut2 (
        .CLK(clk), .ASYNCRESETN(rst_n),
        .I0(b_i0), .I1(b_i1), .SIGNED(b_sgn), .MODE(b_mode),
        .IN_VALID(b_iv), .IN_READY(b_ir),
        .O(b_o), .OUT_VALID(b_ov), .OUT_READY(b_or),
        .ERR(b_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Plain integer interpretation of the operands, then the relation.
    function automatic bit ref_cmp(input int w, input logic [7:0] a,
                                   input logic [7:0] b, input bit s,
                                   input logic [2:0] m);
        longint va, vb;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[w-1]) va -= (longint'(1) << w);
        if (s && b[w-1]) vb -= (longint'(1) << w);
        case (m)
            3'd0: return va == vb;
            3'd1: return va != vb;
            3'd2: return va < vb;
            3'd3: return va >= vb;
            3'd4: return va <= vb;
            3'd5: return va > vb;
            default: return 1'b0;
        endcase
    endfunction

    bit q8[$];
    bit q2[$];
    bit err_m;
    bit pst;
    bit po;

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            err_m = 1'b0;
            pst   = 1'b0;
        end else begin
            chk("in_ready", int'(IN_READY),
                (q8.size() < 2) ? 1 : int'(OUT_READY));
            chk("err", int'(ERR), int'(err_m));
            if (pst) begin
                chk("stall_valid", int'(OUT_VALID), 1);
                chk("stall_o", int'(O), int'(po));
            end
            if (OUT_VALID) chk("valid_has_item", int'(q8.size() > 0), 1);
            if (OUT_VALID && OUT_READY && q8.size() > 0)
                chk("o_stream", int'(O), int'(q8.pop_front()));
            if (IN_VALID && IN_READY) begin
                q8.push_back(ref_cmp(8, I0, I1, SIGNED, MODE));
                if (MODE > 3'd5) err_m = 1'b1;
            end
            pst = OUT_VALID && !OUT_READY;
            po  = O;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
        end else begin
            chk("w2_in_ready", int'(b_ir), 1);
            if (b_ov) chk("w2_valid_has_item", int'(q2.size() > 0), 1);
            if (b_ov && b_or && q2.size() > 0)
                chk("w2_o_stream", int'(b_o), int'(q2.pop_front()));
            if (b_iv && b_ir)
                q2.push_back(ref_cmp(2, {6'd0, b_i0}, {6'd0, b_i1},
                                     b_sgn, b_mode));
        end
    end

    task automatic one(input string nm, input bit s, input logic [2:0] m,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit e);
        @(posedge clk); #1;
        OUT_READY = 1'b1;
        I0 = a; I1 = b; SIGNED = s; MODE = m; IN_VALID = 1'b1;
        @(posedge clk); #1;
        IN_VALID = 1'b0;
        chk({nm, "_early"}, int'(OUT_VALID), 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, int'(OUT_VALID), 1);
        chk(nm, int'(O), int'(e));
    endtask

    task automatic one2(input string nm, input bit s, input logic [2:0] m,
                        input logic [1:0] a, input logic [1:0] b,
                        input bit e);
        @(posedge clk); #1;
        b_i0 = a; b_i1 = b; b_sgn = s; b_mode = m; b_iv = 1'b1;
        @(posedge clk); #1;
        b_iv = 1'b0;
        chk({nm, "_early"}, int'(b_ov), 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, int'(b_ov), 1);
        chk(nm, int'(b_o), int'(e));
    endtask

    initial begin
        logic [9:0] vec;
        I0 = '0; I1 = '0; SIGNED = 1'b0; MODE = '0;
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        b_i0 = '0; b_i1 = '0; b_sgn = 1'b0; b_mode = '0;
        b_iv = 1'b0; b_or = 1'b1;

        #2;
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_o", int'(O), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_in_ready", int'(IN_READY), 1);
        chk("rst_w2_valid", int'(b_ov), 0);
        chk("rst_w2_err", int'(b_err), 0);
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;

        one2("w2_ge_signed", 1'b1, 3'd3, 2'b10, 2'b01, 1'b0);
        one2("w2_ge_unsigned", 1'b0, 3'd3, 2'b10, 2'b01, 1'b1);

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int s = 0; s < 2; s++)
                    for (int m = 0; m < 6; m++) begin
                        @(posedge clk); #1;
                        b_i0 = 2'(a); b_i1 = 2'(b);
                        b_sgn = s[0]; b_mode = 3'(m); b_iv = 1'b1;
                    end
        @(posedge clk); #1;
        b_iv = 1'b0;
        repeat (4) @(posedge clk);
        chk("w2_drained", q2.size(), 0);

        one("lt_signed_min_max", 1'b1, 3'd2, 8'h80, 8'h7F, 1'b1);
        one("lt_unsigned_80_7f", 1'b0, 3'd2, 8'h80, 8'h7F, 1'b0);
        one("gt_signed_max_min", 1'b1, 3'd5, 8'h7F, 8'h80, 1'b1);
        one("eq_55", 1'b1, 3'd0, 8'h55, 8'h55, 1'b1);
        one("ne_55", 1'b1, 3'd1, 8'h55, 8'h55, 1'b0);
        one("le_55", 1'b1, 3'd4, 8'h55, 8'h55, 1'b1);
        one("gt_55", 1'b1, 3'd5, 8'h55, 8'h55, 1'b0);

        // Four back-to-back transfers: valid expected on samples 2..5.
        vec = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            vec[k] = OUT_VALID;
            if (k < 4) begin
                IN_VALID = 1'b1;
                I0 = 8'($urandom); I1 = 8'($urandom);
                SIGNED = 1'($urandom); MODE = 3'($urandom_range(0, 5));
                #1;
                chk("b2b_in_ready", int'(IN_READY), 1);
            end else begin
                IN_VALID = 1'b0;
            end
        end
        chk("b2b_valid_run", int'(vec), 10'b0000111100);

        // Stall: A reaches output, B fills stage 1.
        @(posedge clk); #1;
        OUT_READY = 1'b0;
        I0 = 8'd3; I1 = 8'd9; SIGNED = 1'b0; MODE = 3'd2; IN_VALID = 1'b1;
        @(posedge clk); #1;
        I0 = 8'd3; I1 = 8'd9; MODE = 3'd5;
        @(posedge clk); #1;
        IN_VALID = 1'b0;
        chk("stall_full_in_ready", int'(IN_READY), 0);
        chk("stall_first_valid", int'(OUT_VALID), 1);
        chk("stall_first_o", int'(O), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold_in_ready", int'(IN_READY), 0);
        OUT_READY = 1'b1;
        #1;
        chk("stall_release_in_ready", int'(IN_READY), 1);
        @(posedge clk); #1;
        chk("stall_second_valid", int'(OUT_VALID), 1);
        chk("stall_second_o", int'(O), 0);
        @(posedge clk); #1;
        chk("stall_drained", int'(OUT_VALID), 0);

        one("reserved_mode6", 1'b1, 3'd6, 8'h12, 8'h12, 1'b0);
        chk("err_after_mode6", int'(ERR), 1);
        one("eq_after_err", 1'b0, 3'd0, 8'hA5, 8'hA5, 1'b1);
        chk("err_sticky", int'(ERR), 1);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            I0 = 8'($urandom); I1 = 8'($urandom);
            SIGNED = 1'($urandom);
            MODE = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) I1 = I0;
        end

        @(posedge clk); #1;
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        OUT_READY = 1'b0;
        I0 = 8'd7; I1 = 8'd7; SIGNED = 1'b1; MODE = 3'd0; IN_VALID = 1'b1;
        @(posedge clk); #1;
        MODE = 3'd4;
        @(posedge clk); #1;
        IN_VALID = 1'b0;
        chk("pre_rst_valid", int'(OUT_VALID), 1);
        chk("pre_rst_o", int'(O), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(OUT_VALID), 0);
        chk("midrst_o", int'(O), 0);
        chk("midrst_err", int'(ERR), 0);
        chk("midrst_in_ready", int'(IN_READY), 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        OUT_READY = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(IN_READY), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", int'(OUT_VALID), 0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, pipelined, mode-selectable integer comparator with valid/ready streaming handshake.
- Generalises the fixed 2-bit signed greater-or-equal compare to:
  - any width;
  - signed or unsigned operands;
  - six relations (EQ, NE, LT, GE, LE, GT);
  - a 2-stage registered datapath with backpressure.
- Sits between operand producers (ALU/stream sources) and flag consumers (branch/select logic).
- Maps to iCE40 LUT4 + SB_CARRY fabric.

Parameters:
- WIDTH, 8, operand width in bits (>=2).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- I0  input  WIDTH  left operand.
- I1  input  WIDTH  right operand.
- SIGNED  input  1  1 = two's-complement compare, 0 = unsigned.
- MODE  input  3  relation select: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LE, 5 GT, 6/7 reserved.
- IN_VALID  input  1  operands/SIGNED/MODE valid this cycle.
- IN_READY  output  1  stage 1 can accept this cycle.
- O  output  1  comparison result (I0 rel I1).
- OUT_VALID  output  1  O is valid.
- OUT_READY  input  1  consumer accepts O this cycle.
- ERR  output  1  sticky: a reserved MODE was accepted.

Behaviour:
- Clock and reset: one clock, CLK; reset is asynchronous and active-low on ASYNCRESETN. Reset forces stage valids = 0, OUT_VALID = 0, O = 0, ERR = 0. Reset mid-transaction drops all in-flight results.
- Arithmetic (stage 1 input, combinational):
  - Extend both operands to WIDTH+1 bits: sign-extend if SIGNED, else zero-extend.
  - D = X0 + ~X1 + 1 at WIDTH+1 bits; LT = D[WIDTH].
  - EQ = (I0 == I1).
  - The extra bit makes LT exact with no overflow for all inputs, e.g. signed -128 vs 127 at WIDTH=8.
- Stage 1 register: captures LT, EQ, MODE and s1_valid on a transfer (IN_VALID && IN_READY).
- Stage 2 (output register): O is selected from the stage-1 flags:
  - EQ → EQ; NE → !EQ; LT → LT; GE → !LT; LE → LT|EQ; GT → !(LT|EQ).
  - Reserved MODE gives O = 0.
- Handshake rules:
  - adv2 = !OUT_VALID || OUT_READY.
  - Stage 1 → stage 2 transfer when s1_valid && adv2.
  - IN_READY = !s1_valid || adv2. This is a combinational path from OUT_READY, which is permitted.
  - OUT_VALID set on a stage-2 load; cleared when OUT_READY && no new load.
  - Simultaneous output drain + stage-2 load + stage-1 capture in one cycle gives full throughput: 1 result/cycle.
- Latency: 2 cycles from input transfer to OUT_VALID with OUT_READY held high.
- Stall: while OUT_VALID && !OUT_READY, O, OUT_VALID and the stage-1 contents hold stable. After stage 1 fills, IN_READY = 0; at most 2 results are in flight.
- Ordering: results emerge in input order; no drops or duplicates.
- ERR: set the cycle after stage 1 captures MODE 6 or 7; cleared only by reset.
- Idle: with IN_VALID = 0, no state changes apart from draining.

Decomposition:
- Shared package cmp_pkg:
  - MODE encodings as named constants (CMP_EQ..CMP_GT);
  - MODE width = 3;
  - function for the reserved-mode check.
- One natural sub-module: cmp_flags. Combinational; WIDTH-parametrised extend + subtract (carry chain) producing LT/EQ.
- The pipeline registers and handshake stay in cmp_pipe.

Test Plan:
- WIDTH=2, OUT_READY=1, SIGNED=1, MODE=GE, I0=2'b10 (-2), I1=2'b01 (1) → O=0 exactly 2 cycles later. Same operands with SIGNED=0 (2 ≥ 1) → O=1.
- WIDTH=8, SIGNED=1, MODE=LT, I0=8'h80 (-128), I1=8'h7F (127) → O=1. MODE=GT with I0=8'h7F, I1=8'h80 → O=1. Equal operands 8'h55/8'h55 under EQ/NE/LE/GT → 1/0/1/0.
- Back-to-back stream of 4 transfers with OUT_READY=1 → 4 consecutive OUT_VALID cycles, in-order results, IN_READY never deasserts.
- OUT_READY=0 after first result → OUT_VALID holds with O stable; second input captured, then IN_READY=0. Raise OUT_READY → both results delivered in order, IN_READY=1 again.
- MODE=6 accepted → O=0 with OUT_VALID, ERR=1 one cycle after capture and stays 1 through subsequent valid modes until ASYNCRESETN low.
- Assert ASYNCRESETN low asynchronously mid-stream with 2 results in flight → OUT_VALID=0, O=0, ERR=0 immediately. After release, IN_READY=1 and no stale result appears.
